// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: datapath width, canonical NOP and fetch FSM states.
package rv_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    KILL  = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/fetch_sequencer_if.sv
// I-cache request port and decode-side instruction handshake of the fetch sequencer.
interface fetch_sequencer_if #(
  parameter int XLEN = 32
) ();
  logic            icache_req;
  logic [XLEN-1:0] icache_addr;
  logic            icache_ready;
  logic [XLEN-1:0] icache_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output icache_req, icache_addr, instr_valid, instr, instr_pc,
    input  icache_ready, icache_rdata, instr_ready
  );

  modport slave (
    input  icache_req, icache_addr, instr_valid, instr, instr_pc,
    output icache_ready, icache_rdata, instr_ready
  );
endinterface

// File: rtl/PC_Plus4.sv
// Sequential-PC incrementer; wraps modulo 2^XLEN with no carry out.
module PC_Plus4 #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] sum
);
  assign sum = pc + XLEN'(4);
endmodule

// File: rtl/fetch_skid_buf.sv
// Output register plus one-entry skid; oldest entry always sits in the head register.
module fetch_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic            head_ready,
  output logic            head_valid,
  output logic [XLEN-1:0] head_instr,
  output logic [XLEN-1:0] head_pc,
  output logic            skid_full
);
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            advance;

  // Head may be (re)loaded when empty or being consumed this cycle.
  assign advance = !head_valid || head_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      head_instr <= '0;
      head_pc    <= '0;
      skid_full  <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_full  <= 1'b0;
    end else if (advance) begin
      if (skid_full) begin
        head_valid <= 1'b1;
        head_instr <= skid_instr;
        head_pc    <= skid_pc;
        skid_full  <= load;
        if (load) begin
          skid_instr <= load_instr;
          skid_pc    <= load_pc;
        end
      end else begin
        head_valid <= load;
        if (load) begin
          head_instr <= load_instr;
          head_pc    <= load_pc;
        end
      end
    end else if (load) begin
      skid_full  <= 1'b1;
      skid_instr <= load_instr;
      skid_pc    <= load_pc;
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one I-cache fetch at a time,
// buffers responses for decode and squashes work on execute redirects.
module fetch_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  output logic [XLEN-1:0]   PC,
  fetch_sequencer_if.master bus
);
  import rv_pkg::*;

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] kill_addr;
  logic            req;
  logic            capture;
  logic            skid_full;

  PC_Plus4 #(.XLEN(XLEN)) u_pc_plus4 (
    .pc  (PC),
    .sum (pc_plus4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ISSUE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = (req && !bus.icache_ready) ? KILL : ISSUE;
    end else begin
      case (state)
        ISSUE:   if (req && !bus.icache_ready) state_nxt = WAIT;
        WAIT:    if (bus.icache_ready) state_nxt = ISSUE;
        KILL:    if (bus.icache_ready) state_nxt = ISSUE;
        default: state_nxt = ISSUE;
      endcase
    end
  end

  // Request is gated by rst_n so it drops the instant reset asserts.
  always_comb begin
    req = 1'b0;
    case (state)
      ISSUE:   req = rst_n && fetch_en && !skid_full;
      WAIT:    req = rst_n;
      KILL:    req = rst_n;
      default: req = 1'b0;
    endcase
    capture = req && bus.icache_ready && (state != KILL) && !redirect_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              PC <= RESET_VECTOR & ~XLEN'(3);
    else if (redirect_valid) PC <= redirect_target & ~XLEN'(3);
    else if (capture)        PC <= pc_plus4;
  end

  // The killed request keeps its original address until the cache answers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                kill_addr <= '0;
    else if (redirect_valid && state != KILL) kill_addr <= PC;
  end

  assign bus.icache_req  = req;
  assign bus.icache_addr = (state == KILL) ? kill_addr : PC;

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .load       (capture),
    .load_instr (bus.icache_rdata),
    .load_pc    (bus.icache_addr),
    .head_ready (bus.instr_ready),
    .head_valid (bus.instr_valid),
    .head_instr (bus.instr),
    .head_pc    (bus.instr_pc),
    .skid_full  (skid_full)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hits, miss, back-pressure, redirects, wrap, reset.
module tb_fetch_sequencer;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic        cache_ok;
  int          n_chk;
  int          n_fail;

  fetch_sequencer_if #(.XLEN(32)) bus ();

  fetch_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .PC              (pc),
    .bus             (bus)
  );

  // Cache model: answers in the same cycle whenever cache_ok allows it.
  assign bus.icache_ready = bus.icache_req & cache_ok;
  assign bus.icache_rdata = bus.icache_addr ^ K;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    fetch_en        = 1'b1;
    cache_ok        = 1'b1;
    bus.instr_ready = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_chk           = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    fetch_en        = 1'b1;
    cache_ok        = 1'b1;
    bus.instr_ready = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    #2;
    chk("rst_req",      32'(bus.icache_req),  32'd0);
    chk("rst_valid",    32'(bus.instr_valid), 32'd0);
    chk("rst_instr",    bus.instr,            32'd0);
    chk("rst_instr_pc", bus.instr_pc,         32'd0);
    chk("rst_pc",       pc,                   32'd0);

    // Back-to-back hits
    do_reset();
    chk("hit_req0",  32'(bus.icache_req), 32'd1);
    chk("hit_addr0", bus.icache_addr,     32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hit_valid", 32'(bus.instr_valid), 32'd1);
      chk("hit_pc",    bus.instr_pc,         32'(4 * k));
      chk("hit_instr", bus.instr,            32'(4 * k) ^ K);
    end

    // Three-cycle miss at PC 8
    do_reset();
    step();
    step();
    chk("miss_addr_a", bus.icache_addr, 32'd8);
    cache_ok = 1'b0;
    step();
    chk("miss_addr_b",  bus.icache_addr,       32'd8);
    chk("miss_req_b",   32'(bus.icache_req),   32'd1);
    chk("miss_valid_b", 32'(bus.instr_valid),  32'd0);
    step();
    chk("miss_addr_c",  bus.icache_addr,       32'd8);
    chk("miss_valid_c", 32'(bus.instr_valid),  32'd0);
    step();
    chk("miss_addr_d",  bus.icache_addr,       32'd8);
    cache_ok = 1'b1;
    step();
    chk("miss_valid_e", 32'(bus.instr_valid),  32'd1);
    chk("miss_pc_e",    bus.instr_pc,          32'd8);
    chk("miss_instr_e", bus.instr,             32'd8 ^ K);
    step();
    chk("miss_pc_f",    bus.instr_pc,          32'd12);

    // Decode back-pressure for five cycles
    do_reset();
    bus.instr_ready = 1'b0;
    step();
    chk("bp_pc1",   bus.instr_pc,        32'd0);
    chk("bp_req1",  32'(bus.icache_req), 32'd1);
    chk("bp_addr1", bus.icache_addr,     32'd4);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_hold_valid", 32'(bus.instr_valid), 32'd1);
      chk("bp_hold_pc",    bus.instr_pc,         32'd0);
      chk("bp_hold_instr", bus.instr,            K);
      chk("bp_hold_req",   32'(bus.icache_req),  32'd0);
    end
    bus.instr_ready = 1'b1;
    #1;
    chk("bp_drain_req", 32'(bus.icache_req), 32'd0);
    step();
    chk("bp_pc4",   bus.instr_pc,        32'd4);
    chk("bp_req4",  32'(bus.icache_req), 32'd1);
    chk("bp_addr4", bus.icache_addr,     32'd8);
    step();
    chk("bp_pc8",   bus.instr_pc,        32'd8);
    chk("bp_ins8",  bus.instr,           32'd8 ^ K);

    // Redirect while a miss at PC 12 is outstanding
    do_reset();
    step();
    step();
    step();
    chk("kill_pre_pc", bus.instr_pc, 32'd8);
    cache_ok = 1'b0;
    step();
    chk("kill_wait_addr",  bus.icache_addr,      32'd12);
    chk("kill_wait_valid", 32'(bus.instr_valid), 32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("kill_valid_a", 32'(bus.instr_valid), 32'd0);
    chk("kill_req_a",   32'(bus.icache_req),  32'd1);
    chk("kill_pc_a",    pc,                   32'h100);
    step();
    chk("kill_valid_b", 32'(bus.instr_valid), 32'd0);
    chk("kill_req_b",   32'(bus.icache_req),  32'd1);
    cache_ok = 1'b1;
    step();
    chk("kill_valid_c", 32'(bus.instr_valid), 32'd0);
    chk("kill_addr_c",  bus.icache_addr,      32'h100);
    step();
    chk("kill_valid_d", 32'(bus.instr_valid), 32'd1);
    chk("kill_pc_d",    bus.instr_pc,         32'h100);
    chk("kill_instr_d", bus.instr,            32'h100 ^ K);

    // Misaligned redirect near the top of memory, then wrap
    do_reset();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    chk("wrap_valid_a", 32'(bus.instr_valid), 32'd0);
    chk("wrap_addr_a",  bus.icache_addr,      32'hFFFF_FFFC);
    step();
    chk("wrap_pc_b",    bus.instr_pc,         32'hFFFF_FFFC);
    chk("wrap_instr_b", bus.instr,            32'hFFFF_FFFC ^ K);
    chk("wrap_next_b",  pc,                   32'd0);
    step();
    chk("wrap_pc_c",    bus.instr_pc,         32'd0);
    chk("wrap_instr_c", bus.instr,            K);

    // Reset asserted in the middle of a miss
    do_reset();
    step();
    step();
    bus.instr_ready = 1'b0;
    cache_ok        = 1'b0;
    step();
    chk("mrst_pre_valid", 32'(bus.instr_valid), 32'd1);
    chk("mrst_pre_req",   32'(bus.icache_req),  32'd1);
    chk("mrst_pre_addr",  bus.icache_addr,      32'd8);
    rst_n = 1'b0;
    #1;
    chk("mrst_req",   32'(bus.icache_req),  32'd0);
    chk("mrst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mrst_pc",    pc,                   32'd0);
    @(negedge clk);
    rst_n           = 1'b1;
    cache_ok        = 1'b1;
    bus.instr_ready = 1'b1;
    #1;
    chk("mrst_rel_req",  32'(bus.icache_req), 32'd1);
    chk("mrst_rel_addr", bus.icache_addr,     32'd0);
    step();
    chk("mrst_rel_pc",   bus.instr_pc,        32'd0);
    chk("mrst_rel_vld",  32'(bus.instr_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences the PC_Plus4 adder, redirect targets and the instruction-cache request port. It sits between the PC datapath, the I-cache and the decode stage. It issues one fetch at a time and holds the address stable across cache misses. It buffers returned instructions in a one-deep output register plus a one-entry skid, so decode back-pressure never drops data. Branch/jump redirects flush buffered instructions and discard any in-flight response.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset; bits [1:0] must be 0
- XLEN, 32, address/instruction width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  permits issuing new fetches; in-flight request always completes
- redirect_valid  in  1  one-cycle redirect strobe from execute
- redirect_target  in  XLEN  new PC; bits [1:0] ignored (treated as 00)
- icache_req  out  1  fetch request
- icache_addr  out  XLEN  fetch address (= PC)
- icache_ready  in  1  response strobe; icache_rdata valid this cycle
- icache_rdata  in  XLEN  fetched instruction
- instr_valid  out  1  instr/instr_pc valid to decode
- instr_ready  in  1  decode accepts instruction this cycle
- instr  out  XLEN  instruction to decode
- instr_pc  out  XLEN  address of instr
- PC  out  XLEN  next fetch address

## Operation
- Reset (async, rst_n=0): PC=RESET_VECTOR, state=ISSUE, icache_req=0, instr_valid=0, instr=0, instr_pc=0, skid empty.
- States: ISSUE, WAIT, KILL.
- ISSUE: icache_req = fetch_en & skid empty. Otherwise req=0 and state holds.
  - req & ready (hit): response captured; PC<=PC+4; stay ISSUE.
  - req & !ready: go WAIT.
- WAIT: icache_req=1, icache_addr held at PC. Ready -> capture, PC<=PC+4, go ISSUE.
- KILL: icache_req=1, addr held. Ready -> discard rdata, go ISSUE. PC already holds the redirect target.
- Capture: a response goes to the output register if it is empty or drained this cycle (instr_valid & instr_ready); else to the skid. On drain, skid moves to the output register and the response goes to the skid.
- Order is strictly preserved: output register, then skid, then new response.
- Redirect (highest priority): PC<=target & ~3, and output register and skid clear next cycle.
  - A response arriving in the redirect cycle is discarded.
  - If a request is outstanding without ready, go KILL; otherwise go ISSUE.
  - A redirect in KILL overwrites PC; latest target wins.
- Arithmetic: PC+4 is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0. No carry or flag.
- Once icache_req rises it never falls before ready; fetch_en deassertion does not drop it.

## Timing
- Hit latency: the req&ready edge makes instr_valid=1 on the next cycle with instr_pc = the fetched PC.
- Sustained throughput: one instruction/cycle with continuous hits and instr_ready=1.
- Miss: N wait cycles add N cycles of latency; icache_addr is stable throughout.
- Redirect: first request to the target is issued the cycle after redirect_valid, unless in KILL. instr_valid=0 in that cycle.
- instr_valid & !instr_ready: instr and instr_pc are held stable.
- Skid full: icache_req=0 until decode drains one entry. The request resumes the cycle after the drain.
- Reset release: icache_req=1 (if fetch_en) on the first clock after rst_n rises.

## Structure
- Shared package (rv_pkg): XLEN, INSTR_NOP=32'h0000_0013, fetch state enum {ISSUE, WAIT, KILL}.
- Reuse the existing PC_Plus4 module for the incrementer.
- One natural sub-module: fetch_skid_buf, the output register plus one-entry skid with flush.

## Test plan
- Reset, fetch_en=1, always-hit cache returning addr^32'hA5A5_0000, instr_ready=1 -> instr_pc sequence 0,4,8,12 on consecutive cycles; instr matches.
- Miss: ready delayed 3 cycles at PC=8 -> icache_addr=8 stable for 4 cycles; instr_pc=8 delivered; no duplicate or skipped PC.
- Back-pressure: instr_ready=0 for 5 cycles -> output holds PC 0, skid takes PC 4, icache_req=0. Release -> 4, then 8 delivered in order.
- Redirect to 32'h100 while a miss at PC=12 is outstanding -> KILL; the late response is discarded; next instr_pc=32'h100; no instr_pc=12 is ever emitted.
- Redirect to 32'hFFFF_FFFE -> fetch at 32'hFFFF_FFFC, then 0 (wrap).
- Reset asserted in WAIT mid-miss -> icache_req=0 and instr_valid=0 immediately; after release, fetch restarts at RESET_VECTOR.
